multi_bank_cmd_scheduler: RTL and testbench

//   Parametrised successor to the single-bank command scheduler: tracks NUM_BANKS banks with per-bank

---
 rtl/command_definition_pkg.sv | 28 ++
 rtl/bank_timing_tracker.sv | 65 ++++++
 rtl/multi_bank_cmd_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_multi_bank_cmd_scheduler.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/command_definition_pkg.sv
// Shared command encoding, scheduler states and timer sizing helpers for the multi-bank command scheduler.
package command_definition_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } bank_command_t;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_REFRESH = 2'd2
    } sched_state_t;

    // Bits needed for a countdown timer that must hold values up to max_t.
    function automatic int timer_width(input int max_t);
        return (max_t < 1) ? 1 : $clog2(max_t + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bank_timing_tracker.sv
// Per-bank open-row state and same-bank timing counters; reports which command classes are currently legal.
module bank_timing_tracker #(
    parameter int ROW_W = 16,
    parameter int TW    = 5,
    parameter int T_RCD = 4,
    parameter int T_RP  = 4,
    parameter int T_RAS = 10,
    parameter int T_RTP = 3,
    parameter int T_WR  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act_issue,
    input  logic             rd_issue,
    input  logic             wr_issue,
    input  logic             pre_issue,
    input  logic [ROW_W-1:0] act_row,
    output logic             is_open,
    output logic [ROW_W-1:0] open_row,
    output logic             act_ok,
    output logic             rw_ok,
    output logic             pre_ok,
    output logic             trp_done
);

    logic [TW-1:0] trcd, tras, trp, trtp, twr;

    // A reload never shortens a pending constraint; idle timers count down and park at zero.
    function automatic logic [TW-1:0] next_timer(input logic [TW-1:0] cur, input logic load,
                                                 input logic [TW-1:0] t_m1);
        if (load)
            return (cur > t_m1) ? cur : t_m1;
        return (cur == '0) ? '0 : cur - 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_open  <= 1'b0;
            open_row <= '0;
            trcd     <= '0;
            tras     <= '0;
            trp      <= '0;
            trtp     <= '0;
            twr      <= '0;
        end else begin
            if (act_issue) begin
                is_open  <= 1'b1;
                open_row <= act_row;
            end else if (pre_issue) begin
                is_open  <= 1'b0;
            end
            trcd <= next_timer(trcd, act_issue, TW'(T_RCD - 1));
            tras <= next_timer(tras, act_issue, TW'(T_RAS - 1));
            trp  <= next_timer(trp,  pre_issue, TW'(T_RP - 1));
            trtp <= next_timer(trtp, rd_issue,  TW'(T_RTP - 1));
            twr  <= next_timer(twr,  wr_issue,  TW'(T_WR - 1));
        end
    end

    assign trp_done = (trp == '0);
    assign act_ok   = !is_open && trp_done;
    assign rw_ok    = is_open && (trcd == '0);
    assign pre_ok   = is_open && (tras == '0) && (trtp == '0) && (twr == '0);

endmodule

// File: rtl/multi_bank_cmd_scheduler.sv
// In-order multi-bank command scheduler between issue FIFO and PHY, with refresh-due tracking.
// Optional four-activate window enabled by defining CMD_SCH_TFAW_EN.
module multi_bank_cmd_scheduler
    import command_definition_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int ROW_W     = 16,
    parameter int T_RCD     = 4,
    parameter int T_RP      = 4,
    parameter int T_RAS     = 10,
    parameter int T_RTP     = 3,
    parameter int T_WR      = 6,
    parameter int T_CCD     = 4,
    parameter int T_RRD     = 2,
    parameter int T_WTR     = 5,
    parameter int T_RTW     = 6,
    parameter int T_RFC     = 30,
    parameter int T_REFI    = 780,
    parameter int T_FAW     = 16,
    localparam int BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_init_done,
    input  logic                 i_cmd_valid,
    input  bank_command_t        i_cmd,
    input  logic [BW-1:0]        i_bank,
    input  logic [ROW_W-1:0]     i_row,
    output logic                 o_cmd_ready,
    output bank_command_t        o_cmd,
    output logic [BW-1:0]        o_bank,
    output logic [ROW_W-1:0]     o_row,
    output logic                 o_wdata_ren,
    output logic [NUM_BANKS-1:0] o_bank_open,
    output logic                 o_refresh_due,
    output logic                 o_cmd_error
);

    localparam int T_MAX = max_int(max_int(max_int(T_RCD, T_RP), max_int(T_RAS, T_RTP)),
                                   max_int(max_int(T_WR, T_CCD),
                                           max_int(max_int(T_RRD, T_WTR),
                                                   max_int(T_RTW, max_int(T_RFC, T_FAW)))));
    localparam int TW = timer_width(T_MAX);
    localparam int RW = timer_width(T_REFI);

    sched_state_t state, state_next;

    logic [TW-1:0]        tccd, trrd, twtr, trtw, trfc;
    logic [RW-1:0]        refi_cnt;
    logic [NUM_BANKS-1:0] bank_open, act_ok, rw_ok, pre_ok, trp_done;
    logic [ROW_W-1:0]     bank_row [NUM_BANKS];
    logic                 head_open, faw_ok, state_ok, timing_ok;
    logic                 accept, issue, illegal;
    logic                 is_act, is_rd, is_wr, is_pre, is_ref;

    function automatic logic [TW-1:0] next_timer(input logic [TW-1:0] cur, input logic load,
                                                 input logic [TW-1:0] t_m1);
        if (load)
            return (cur > t_m1) ? cur : t_m1;
        return (cur == '0) ? '0 : cur - 1'b1;
    endfunction

    assign head_open = bank_open[i_bank];

    // state_ok separates protocol-illegal heads (dropped with an error) from timing stalls.
    always_comb begin
        state_ok  = 1'b0;
        timing_ok = 1'b0;
        case (i_cmd)
            CMD_ACT: begin
                state_ok  = !head_open;
                timing_ok = act_ok[i_bank] && (trrd == '0) && faw_ok;
            end
            CMD_RD: begin
                state_ok  = head_open;
                timing_ok = rw_ok[i_bank] && (tccd == '0) && (twtr == '0);
            end
            CMD_WR: begin
                state_ok  = head_open;
                timing_ok = rw_ok[i_bank] && (tccd == '0) && (trtw == '0);
            end
            CMD_PRE: begin
                state_ok  = head_open;
                timing_ok = pre_ok[i_bank];
            end
            CMD_REF: begin
                state_ok  = (bank_open == '0);
                timing_ok = &trp_done;
            end
            default: begin
                state_ok  = 1'b0;
                timing_ok = 1'b0;
            end
        endcase
    end

    assign accept      = (state == ST_RUN) && i_cmd_valid && (!state_ok || timing_ok);
    assign issue       = accept && state_ok;
    assign illegal     = accept && !state_ok;
    assign o_cmd_ready = accept;
    assign is_act      = issue && (i_cmd == CMD_ACT);
    assign is_rd       = issue && (i_cmd == CMD_RD);
    assign is_wr       = issue && (i_cmd == CMD_WR);
    assign is_pre      = issue && (i_cmd == CMD_PRE);
    assign is_ref      = issue && (i_cmd == CMD_REF);

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic sel;
        assign sel = (i_bank == BW'(g));

        bank_timing_tracker #(
            .ROW_W (ROW_W),
            .TW    (TW),
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS),
            .T_RTP (T_RTP),
            .T_WR  (T_WR)
        ) u_tracker (
            .clk       (clk),
            .rst       (rst),
            .act_issue (is_act && sel),
            .rd_issue  (is_rd && sel),
            .wr_issue  (is_wr && sel),
            .pre_issue (is_pre && sel),
            .act_row   (i_row),
            .is_open   (bank_open[g]),
            .open_row  (bank_row[g]),
            .act_ok    (act_ok[g]),
            .rw_ok     (rw_ok[g]),
            .pre_ok    (pre_ok[g]),
            .trp_done  (trp_done[g])
        );
    end

`ifdef CMD_SCH_TFAW_EN
    // Countdown per remembered ACT, newest in slot 0; slot 3 reaching zero frees the window.
    logic [TW-1:0] faw_win [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                faw_win[i] <= '0;
        end else if (is_act) begin
            faw_win[0] <= TW'(T_FAW - 1);
            for (int i = 1; i < 4; i++)
                faw_win[i] <= next_timer(faw_win[i-1], 1'b0, '0);
        end else begin
            for (int i = 0; i < 4; i++)
                faw_win[i] <= next_timer(faw_win[i], 1'b0, '0);
        end
    end

    assign faw_ok = (faw_win[3] == '0);
`else
    assign faw_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_INIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:    if (i_init_done) state_next = ST_RUN;
            ST_RUN:     if (is_ref) state_next = ST_REFRESH;
            ST_REFRESH: if (trfc == '0) state_next = ST_RUN;
            default:    state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tccd <= '0;
            trrd <= '0;
            twtr <= '0;
            trtw <= '0;
            trfc <= '0;
        end else begin
            tccd <= next_timer(tccd, is_rd || is_wr, TW'(T_CCD - 1));
            trrd <= next_timer(trrd, is_act, TW'(T_RRD - 1));
            twtr <= next_timer(twtr, is_wr, TW'(T_WTR - 1));
            trtw <= next_timer(trtw, is_rd, TW'(T_RTW - 1));
            trfc <= next_timer(trfc, is_ref, TW'(T_RFC - 1));
        end
    end

    // Refresh interval only runs once the PHY is up; due latches until a REF goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refi_cnt      <= RW'(T_REFI - 1);
            o_refresh_due <= 1'b0;
        end else if (is_ref) begin
            refi_cnt      <= RW'(T_REFI - 1);
            o_refresh_due <= 1'b0;
        end else if (state != ST_INIT) begin
            if (refi_cnt == '0)
                o_refresh_due <= 1'b1;
            else
                refi_cnt <= refi_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cmd       <= CMD_NOP;
            o_bank      <= '0;
            o_row       <= '0;
            o_wdata_ren <= 1'b0;
            o_cmd_error <= 1'b0;
        end else begin
            o_cmd       <= issue ? i_cmd : CMD_NOP;
            o_bank      <= issue ? i_bank : '0;
            o_row       <= is_act ? i_row : ((is_rd || is_wr) ? bank_row[i_bank] : '0);
            o_wdata_ren <= is_wr;
            o_cmd_error <= illegal;
        end
    end

    assign o_bank_open = bank_open;

endmodule

// File: tb/tb_multi_bank_cmd_scheduler.sv
// Self-checking bench: issue-FIFO model feeding the scheduler, scoreboard of expected PHY events.
module tb_multi_bank_cmd_scheduler;
    import command_definition_pkg::*;

    localparam int NB    = 8;
    localparam int BW    = 3;
    localparam int ROW_W = 16;
`ifdef CMD_SCH_TFAW_EN
    localparam int FAW_GAP = 10;
`else
    localparam int FAW_GAP = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             i_init_done;
    logic             i_cmd_valid;
    bank_command_t    i_cmd;
    logic [BW-1:0]    i_bank;
    logic [ROW_W-1:0] i_row;
    logic             o_cmd_ready;
    bank_command_t    o_cmd;
    logic [BW-1:0]    o_bank;
    logic [ROW_W-1:0] o_row;
    logic             o_wdata_ren;
    logic [NB-1:0]    o_bank_open;
    logic             o_refresh_due;
    logic             o_cmd_error;

    always #5 clk = ~clk;

    multi_bank_cmd_scheduler #(.NUM_BANKS(NB), .ROW_W(ROW_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_init_done   (i_init_done),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd         (i_cmd),
        .i_bank        (i_bank),
        .i_row         (i_row),
        .o_cmd_ready   (o_cmd_ready),
        .o_cmd         (o_cmd),
        .o_bank        (o_bank),
        .o_row         (o_row),
        .o_wdata_ren   (o_wdata_ren),
        .o_bank_open   (o_bank_open),
        .o_refresh_due (o_refresh_due),
        .o_cmd_error   (o_cmd_error)
    );

    typedef struct {
        bank_command_t    cmd;
        logic [BW-1:0]    bank;
        logic [ROW_W-1:0] row;
        logic             err;
        int               gap;
        logic             gap_min;
        logic [NB-1:0]    open;
    } vec_t;

    vec_t fifo_q[$];
    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    int   last_evt = 0;

    function automatic vec_t mk(bank_command_t c, int b, int r, bit e, int g, bit gm, int op);
        vec_t v;
        v.cmd     = c;
        v.bank    = BW'(b);
        v.row     = ROW_W'(r);
        v.err     = e;
        v.gap     = g;
        v.gap_min = gm;
        v.open    = NB'(op);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_min(input string name, input int act, input int min_val);
        checks++;
        if (act < min_val) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required>=%0d (t=%0t)", name, act, min_val, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"}, 32'(o_cmd), 32'(CMD_NOP));
        check({tag, "_bank"}, 32'(o_bank), 0);
        check({tag, "_row"}, 32'(o_row), 0);
        check({tag, "_wdata_ren"}, 32'(o_wdata_ren), 0);
        check({tag, "_cmd_ready"}, 32'(o_cmd_ready), 0);
        check({tag, "_bank_open"}, 32'(o_bank_open), 0);
        check({tag, "_refresh_due"}, 32'(o_refresh_due), 0);
        check({tag, "_cmd_error"}, 32'(o_cmd_error), 0);
    endtask

    // Registered outputs are sampled on the falling edge and matched against the scoreboard head.
    task automatic checkOutput();
        vec_t e;
        if (o_cmd != CMD_NOP || o_cmd_error) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(o_cmd), 32'(CMD_NOP));
            end else begin
                e = exp_q.pop_front();
                check("cmd", 32'(o_cmd), 32'(e.err ? CMD_NOP : e.cmd));
                check("cmd_error", 32'(o_cmd_error), 32'(e.err));
                check("bank_open", 32'(o_bank_open), 32'(e.open));
                if (!e.err) begin
                    check("bank", 32'(o_bank), 32'(e.bank));
                    check("wdata_ren", 32'(o_wdata_ren), 32'(e.cmd == CMD_WR));
                    if (e.cmd == CMD_ACT)
                        check("row", 32'(o_row), 32'(e.row));
                end
                if (e.gap != 0) begin
                    if (e.gap_min)
                        check_min("gap_min", cycle - last_evt, e.gap);
                    else
                        check("gap", 32'(cycle - last_evt), 32'(e.gap));
                end
            end
            last_evt = cycle;
        end else begin
            check("idle_wdata_ren", 32'(o_wdata_ren), 0);
        end
    endtask

    // Present the FIFO head, then pop it if the scheduler accepted it on this edge.
    task automatic applyStimulus();
        logic rdy;
        if (fifo_q.size() > 0) begin
            i_cmd_valid = 1'b1;
            i_cmd       = fifo_q[0].cmd;
            i_bank      = fifo_q[0].bank;
            i_row       = fifo_q[0].row;
        end else begin
            i_cmd_valid = 1'b0;
            i_cmd       = CMD_NOP;
            i_bank      = '0;
            i_row       = '0;
        end
        #1;
        rdy = o_cmd_ready;
        @(posedge clk);
        cycle++;
        if (rdy && fifo_q.size() > 0)
            void'(fifo_q.pop_front());
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput();
        applyStimulus();
    endtask

    task automatic load(input vec_t v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() > 0 || fifo_q.size() > 0) && n < 400) begin
            tick();
            n++;
        end
        check({name, "_pending"}, 32'(exp_q.size() + fifo_q.size()), 0);
        fifo_q.delete();
        exp_q.delete();
    endtask

    vec_t tbl_main [11];
    vec_t tbl_faw  [10];
    vec_t tbl_ref  [3];
    vec_t tbl_rst  [2];

    initial begin
        tbl_main[0]  = mk(CMD_ACT, 0, 'h1234, 0, 0, 0, 'h01);
        tbl_main[1]  = mk(CMD_RD,  0, 0,      0, 4, 0, 'h01);
        tbl_main[2]  = mk(CMD_ACT, 1, 'h0055, 0, 1, 0, 'h03);
        tbl_main[3]  = mk(CMD_WR,  1, 0,      0, 5, 0, 'h03);
        tbl_main[4]  = mk(CMD_RD,  1, 0,      0, 5, 0, 'h03);
        tbl_main[5]  = mk(CMD_RD,  3, 0,      1, 1, 0, 'h03);
        tbl_main[6]  = mk(CMD_PRE, 0, 0,      0, 1, 0, 'h02);
        tbl_main[7]  = mk(CMD_PRE, 1, 0,      0, 1, 0, 'h00);
        tbl_main[8]  = mk(CMD_ACT, 0, 'h0007, 0, 3, 0, 'h01);
        tbl_main[9]  = mk(CMD_ACT, 0, 'h0009, 1, 1, 0, 'h01);
        tbl_main[10] = mk(CMD_PRE, 0, 0,      0, 9, 0, 'h00);

        for (int i = 0; i < 5; i++)
            tbl_faw[i] = mk(CMD_ACT, i, 'h100 + i, 0, (i == 0) ? 0 : ((i == 4) ? FAW_GAP : 2), 0,
                            (1 << (i + 1)) - 1);
        for (int i = 0; i < 5; i++)
            tbl_faw[5 + i] = mk(CMD_PRE, i, 0, 0, 0, 0, 'h1F & ~((1 << (i + 1)) - 1));

        tbl_ref[0] = mk(CMD_REF, 0, 0,      0, 0,  0, 'h00);
        tbl_ref[1] = mk(CMD_ACT, 2, 'hBEEF, 0, 30, 1, 'h04);
        tbl_ref[2] = mk(CMD_PRE, 2, 0,      0, 0,  0, 'h00);

        tbl_rst[0] = mk(CMD_ACT, 5, 'h0A5A, 0, 0, 0, 'h20);
        tbl_rst[1] = mk(CMD_ACT, 6, 'h0B6B, 0, 2, 0, 'h60);

        rst         = 1'b1;
        i_init_done = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd       = CMD_NOP;
        i_bank      = '0;
        i_row       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Scheduler must ignore a valid head until the PHY reports init done.
        i_cmd_valid = 1'b1;
        i_cmd       = CMD_ACT;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("init_ready", 32'(o_cmd_ready), 0);
        end
        i_cmd_valid = 1'b0;
        i_cmd       = CMD_NOP;
        i_init_done = 1'b1;
        $display("[TB] init done, idling for refresh interval");

        repeat (770) tick();
        #1;
        check("refresh_due_early", 32'(o_refresh_due), 0);
        repeat (20) tick();
        #1;
        check("refresh_due_set", 32'(o_refresh_due), 1);
        repeat (20) tick();
        #1;
        check("refresh_due_hold", 32'(o_refresh_due), 1);

        for (int i = 0; i < 3; i++) load(tbl_ref[i]);
        drain("refresh");
        #1;
        check("refresh_due_cleared", 32'(o_refresh_due), 0);

        $display("[TB] main command table");
        for (int i = 0; i < 11; i++) load(tbl_main[i]);
        drain("main");

        repeat (20) tick();
        $display("[TB] four-activate stream, expected last gap %0d", FAW_GAP);
        for (int i = 0; i < 10; i++) load(tbl_faw[i]);
        drain("faw");

        repeat (5) tick();
        for (int i = 0; i < 2; i++) load(tbl_rst[i]);
        drain("pre_reset");
        #2;
        rst         = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd       = CMD_RD;
        i_bank      = 3'd5;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        i_init_done = 1'b0;
        rst         = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("postreset_ready", 32'(o_cmd_ready), 0);
            check("postreset_open", 32'(o_bank_open), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
